ad7822_emul: RTL and testbench

Synthesizable cycle-level emulation of the AD7822 8-bit ADC parallel interface: the responder end of the convst/cs/rd/eoc handshake that the filter drives as initiator. It takes a digital sample stream in place of the analog input and answers CONVST_n, CS_n and RD_n with EOC_n and DB exactly as the filter expects. It lets the full filter datapath run in FPGA loopback and in pure-digital regression without the analog ADC model.

---
 rtl/ad7822_emul.sv | 149 ++++++++++++++
 tb/tb_ad7822_emul.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad7822_emul.sv
// ad7822_emul: cycle-level emulation of the AD7822 8-bit ADC parallel interface.
// It is the responder end of the convst/cs/rd/eoc handshake. A digital sample
// stream stands in for the analog input.
//
// Ports:
//   clk          system clock (same domain as the initiator)
//   reset_n      asynchronous active-low reset
//   sample_in    digital "analog" input, 0x00 = 0 V, 0xFF = full scale
//   convst_n     conversion start, falling edge starts a conversion
//   cs_n, rd_n   chip select / read strobe, active low
//   pd_n         power-down, active low
//   eoc_n        end of conversion, low until the result is read
//   db, db_oe    registered read data and its valid flag
//   overrun_cnt  saturating count of lost/ignored conversions
//
// Build option: define ADC_EMUL_OVERRUN_EN to implement overrun_cnt;
// otherwise it is tied to 0x00.
module ad7822_emul #(
    parameter int unsigned CONV_CYCLES = 21
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] sample_in,
    input  logic       convst_n,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       pd_n,
    output logic       eoc_n,
    output logic [7:0] db,
    output logic       db_oe,
    output logic [7:0] overrun_cnt
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EOC     = 2'd2,
        READ    = 2'd3
    } state_t;

    state_t              state;
    logic                convst_q;
    logic [DATA_W-1:0]   hold;
    logic [DATA_W-1:0]   result;
    logic [CNT_W-1:0]    cnt;

    logic start_c;
    logic rd_c;

    // Falling-edge detect on convst_n; convst_q resets low so a low level at
    // reset release is not mistaken for an edge.
    assign start_c = convst_q & ~convst_n;
    assign rd_c    = ~cs_n & ~rd_n;

    // Conversion handshake FSM with registered eoc_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            convst_q <= 1'b0;
            hold     <= '0;
            result   <= '0;
            cnt      <= '0;
            eoc_n    <= 1'b1;
        end else begin
            convst_q <= convst_n;
            if (!pd_n) begin
                // Power-down aborts everything but keeps the last result.
                state <= IDLE;
                eoc_n <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_c) begin
                            hold  <= sample_in;
                            cnt   <= CNT_W'(CONV_CYCLES - 1);
                            state <= CONVERT;
                        end
                    end
                    CONVERT: begin
                        // Starts here are ignored; the overrun counter sees them.
                        if (cnt == '0) begin
                            result <= hold;
                            eoc_n  <= 1'b0;
                            state  <= EOC;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    EOC: begin
                        // A start with the result unread discards it.
                        if (start_c) begin
                            eoc_n <= 1'b1;
                            hold  <= sample_in;
                            cnt   <= CNT_W'(CONV_CYCLES - 1);
                            state <= CONVERT;
                        end else if (rd_c) begin
                            state <= READ;
                        end
                    end
                    READ: begin
                        // A start ends the read and begins a new conversion.
                        if (start_c) begin
                            eoc_n <= 1'b1;
                            hold  <= sample_in;
                            cnt   <= CNT_W'(CONV_CYCLES - 1);
                            state <= CONVERT;
                        end else if (!rd_c) begin
                            eoc_n <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Read port, active in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db    <= '0;
            db_oe <= 1'b0;
        end else begin
            db_oe <= rd_c;
            db    <= rd_c ? result : '0;
        end
    end

`ifdef ADC_EMUL_OVERRUN_EN
    logic ovr_event_c;

    // A start lost in CONVERT or one that discards an unread result.
    assign ovr_event_c = pd_n & start_c & ((state == CONVERT) | (state == EOC));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_cnt <= '0;
        end else if (ovr_event_c && (overrun_cnt != '1)) begin
            overrun_cnt <= overrun_cnt + CNT_W'(1);
        end
    end
`else
    assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_ad7822_emul.sv
// Self-checking bench for ad7822_emul: directed scenarios with literal
// expectations plus a randomized run against a behavioural reference model.
module tb_ad7822_emul;

    localparam int CONV = 21;
`ifdef ADC_EMUL_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] sample_in = 8'h00;
    logic       convst_n = 1'b1;
    logic       cs_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       pd_n = 1'b1;
    logic       eoc_n;
    logic [7:0] db;
    logic       db_oe;
    logic [7:0] overrun_cnt;

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    ad7822_emul #(.CONV_CYCLES(CONV)) dut (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in),
        .convst_n(convst_n), .cs_n(cs_n), .rd_n(rd_n), .pd_n(pd_n),
        .eoc_n(eoc_n), .db(db), .db_oe(db_oe), .overrun_cnt(overrun_cnt)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // A conversion is just "result appears at edge done_at"; a pending result
    // is eoc low, and `reading` remembers that the host has begun its read.
    int         cyc = 0;
    int         done_at = -1;
    logic [7:0] m_held = 8'h00;
    logic [7:0] m_result = 8'h00;
    logic       m_eoc = 1'b1;
    logic       m_reading = 1'b0;
    int         m_ovr = 0;
    logic       m_prev_cv = 1'b0;
    logic [7:0] e_db = 8'h00;
    logic       e_oe = 1'b0;
    logic       m_st, m_rd;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0; done_at = -1; m_held = 8'h00; m_result = 8'h00;
            m_eoc = 1'b1; m_reading = 1'b0; m_ovr = 0; m_prev_cv = 1'b0;
            e_db = 8'h00; e_oe = 1'b0;
        end else begin
            m_st = m_prev_cv && !convst_n;
            m_rd = !cs_n && !rd_n;
            e_oe = m_rd;
            e_db = m_rd ? m_result : 8'h00;
            if (!pd_n) begin
                done_at = -1; m_eoc = 1'b1; m_reading = 1'b0;
            end else if (done_at >= 0) begin
                if (m_st) m_ovr++;
                if (cyc == done_at) begin
                    m_result = m_held; m_eoc = 1'b0; done_at = -1; m_reading = 1'b0;
                end
            end else if (!m_eoc) begin
                if (m_st && !m_reading) m_ovr++;
                if (m_st) begin
                    m_eoc = 1'b1; m_held = sample_in; done_at = cyc + CONV;
                end else if (m_reading && !m_rd) begin
                    m_eoc = 1'b1;
                end else if (m_rd) begin
                    m_reading = 1'b1;
                end
            end else if (m_st) begin
                m_held = sample_in; done_at = cyc + CONV;
            end
            m_prev_cv = convst_n;
            cyc++;
        end
    end

    function automatic int exp_ovr();
        if (!OVR_EN) return 0;
        return (m_ovr > 255) ? 255 : m_ovr;
    endfunction

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("eoc_n", int'(eoc_n), int'(m_eoc));
            chk("db", int'(db), int'(e_db));
            chk("db_oe", int'(db_oe), int'(e_oe));
            chk("overrun_cnt", int'(overrun_cnt), exp_ovr());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; convst_n = 1'b1; cs_n = 1'b1; rd_n = 1'b1; pd_n = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    // Returns just after the start edge.
    task automatic start_pulse(input logic [7:0] s);
        sample_in = s; convst_n = 1'b0;
        tick();
        convst_n = 1'b1;
    endtask

    // Cycles from now until eoc_n is seen low; bounded.
    task automatic wait_eoc(output int k);
        k = 0;
        while (eoc_n !== 1'b0 && k < 100) begin
            tick();
            k++;
        end
    endtask

    task automatic do_read(output logic [7:0] d, output logic oe);
        cs_n = 1'b0; rd_n = 1'b0;
        tick();
        d = db; oe = db_oe;
        tick();
        cs_n = 1'b1; rd_n = 1'b1;
        tick();
    endtask

    int         k;
    logic [7:0] d;
    logic       oe;
    bit         eoc_seen;

    initial begin
        do_reset();
        chk("reset eoc_n", int'(eoc_n), 1);
        chk("reset db", int'(db), 0);
        chk("reset db_oe", int'(db_oe), 0);
        chk("reset overrun", int'(overrun_cnt), 0);
        cmp_en = 1'b1;

        // Basic conversion.
        start_pulse(8'hA5);
        wait_eoc(k);
        chk("basic eoc latency", k, 21);
        do_read(d, oe);
        chk("basic db", int'(d), 8'hA5);
        chk("basic db_oe", int'(oe), 1);
        chk("basic eoc release", int'(eoc_n), 1);

        // Track-and-hold: input changes right after the start edge.
        start_pulse(8'h10);
        sample_in = 8'hF0;
        wait_eoc(k);
        chk("t&h latency", k, 21);
        do_read(d, oe);
        chk("t&h db", int'(d), 8'h10);

        // Start during conversion is ignored.
        do_reset();
        start_pulse(8'h5A);
        tick(4);
        convst_n = 1'b0;
        tick();
        convst_n = 1'b1;
        wait_eoc(k);
        chk("busy start eoc latency", k + 5, 21);
        chk("busy start overrun", int'(overrun_cnt), OVR_EN ? 1 : 0);
        do_read(d, oe);
        chk("busy start db", int'(d), 8'h5A);

        // Unread result overwritten by a new start.
        do_reset();
        start_pulse(8'h11);
        wait_eoc(k);
        start_pulse(8'h33);
        chk("unread eoc high", int'(eoc_n), 1);
        wait_eoc(k);
        chk("unread eoc latency", k, 21);
        do_read(d, oe);
        chk("unread db", int'(d), 8'h33);
        chk("unread overrun", int'(overrun_cnt), OVR_EN ? 1 : 0);

        // Power-down mid-conversion.
        do_reset();
        start_pulse(8'h5C);
        wait_eoc(k);
        do_read(d, oe);
        start_pulse(8'h99);
        tick(9);
        pd_n = 1'b0;
        eoc_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            convst_n = 1'b0; tick();
            convst_n = 1'b1; tick();
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (eoc_n === 1'b0) eoc_seen = 1'b1;
        end
        chk("pd no eoc", int'(eoc_seen), 0);
        pd_n = 1'b1;
        tick(2);
        do_read(d, oe);
        chk("pd keeps result", int'(d), 8'h5C);

        // Reset mid-read, then convst_n held low through release.
        start_pulse(8'hC3);
        wait_eoc(k);
        cs_n = 1'b0; rd_n = 1'b0;
        tick();
        chk("pre-reset db_oe", int'(db_oe), 1);
        chk("pre-reset db", int'(db), 8'hC3);
        #3;
        reset_n = 1'b0;
        convst_n = 1'b0;
        #1;
        chk("async reset db", int'(db), 0);
        chk("async reset db_oe", int'(db_oe), 0);
        chk("async reset eoc_n", int'(eoc_n), 1);
        cs_n = 1'b1; rd_n = 1'b1;
        tick();
        reset_n = 1'b1;
        eoc_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (eoc_n === 1'b0) eoc_seen = 1'b1;
        end
        chk("low convst at release", int'(eoc_seen), 0);
        convst_n = 1'b1;
        tick(2);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            sample_in = 8'($urandom);
            convst_n  = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
            cs_n      = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            rd_n      = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            pd_n      = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        convst_n = 1'b1; cs_n = 1'b1; rd_n = 1'b1; pd_n = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
